// File: rtl/incr_pkg.sv
// Shared defaults and the result-register state type for the incr_arbiter block.
package incr_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 4;

    // EMPTY: no result held; FULL: result register holds a valid result.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/incr_rr_pick.sv
// Round-robin picker: one-hot grant on the first valid requester at or after rr_ptr.
module incr_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [PW-1:0]   rr_ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant
);

    always_comb begin
        logic [PW:0] idx;
        logic        found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            // rr_ptr is always < NREQ, so one subtraction is enough to wrap.
            idx = {1'b0, rr_ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (enable && !found && req_valid[idx[PW-1:0]]) begin
                grant[idx[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/incr_arbiter.sv
// Round-robin arbiter sharing one W-bit +1 datapath among NREQ requesters.
// Define INCR_ARBITER_SAT_EN to saturate on an all-ones operand instead of wrapping.
module incr_arbiter
    import incr_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_data,
    output logic [IW-1:0]     res_id,
    output logic              res_ovf
);

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   rr_ptr;
    logic            accept_en;
    logic [NREQ-1:0] grant;
    logic            xfer;
    logic [IW-1:0]   gnt_idx;
    logic [W-1:0]    operand;
    logic [W:0]      sum;
    logic [W-1:0]    result;

    // Gated with rst_n so no grant is visible while reset is held.
    assign accept_en = rst_n && ((state == EMPTY) || res_ready);

    incr_rr_pick #(
        .NREQ (NREQ),
        .PW   (IW)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .enable    (accept_en),
        .grant     (grant)
    );

    assign xfer = |grant;

    always_comb begin
        gnt_idx = '0;
        operand = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_idx = IW'(i);
                operand = req_data[i*W +: W];
            end
        end
    end

    // The single shared incrementer; the carry out flags an all-ones operand.
    assign sum = {1'b0, operand} + (W+1)'(1);
`ifdef INCR_ARBITER_SAT_EN
    assign result = sum[W] ? {W{1'b1}} : sum[W-1:0];
`else
    assign result = sum[W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (xfer) state_next = FULL;
            FULL:  if (res_ready) state_next = xfer ? FULL : EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        res_valid = (state == FULL);
        req_ready = grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_id   <= '0;
            res_ovf  <= 1'b0;
            rr_ptr   <= '0;
        end else if (xfer) begin
            res_data <= result;
            res_id   <= gnt_idx;
            res_ovf  <= sum[W];
            rr_ptr   <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);
        end
    end

endmodule

// File: tb/tb_incr_arbiter.sv
// Directed bench for incr_arbiter (NREQ=4, W=4); honours INCR_ARBITER_SAT_EN for wrap expectations.
module tb_incr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;

`ifdef INCR_ARBITER_SAT_EN
    localparam logic [W-1:0] WRAP_RES = 4'hF;
`else
    localparam logic [W-1:0] WRAP_RES = 4'h0;
`endif

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_data;
    logic [1:0]        res_id;
    logic              res_ovf;

    int num_checks = 0;
    int num_errors = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [NREQ-1:0]   rv;
        logic [NREQ*W-1:0] data;
        logic              rr;
        logic [NREQ-1:0]   rdy;
        logic              vld;
        logic [W-1:0]      rdata;
        logic [1:0]        id;
        logic              ovf;
    } vec_t;

    vec_t vecs[13];

    incr_arbiter #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] rdy, input logic vld,
                              input logic [3:0] rdata, input logic [1:0] id, input logic ovf);
        check({tag, " req_ready"}, 32'(req_ready), 32'(rdy));
        check({tag, " res_valid"}, 32'(res_valid), 32'(vld));
        check({tag, " res_data"},  32'(res_data),  32'(rdata));
        check({tag, " res_id"},    32'(res_id),    32'(id));
        check({tag, " res_ovf"},   32'(res_ovf),   32'(ovf));
    endtask

    task automatic drive(input logic [3:0] rv, input logic [15:0] data, input logic rr);
        req_valid = rv;
        req_data  = data;
        res_ready = rr;
    endtask

    // Advance to just after the next rising edge, apply inputs, then sample on the falling edge.
    task automatic cycle(input logic [3:0] rv, input logic [15:0] data, input logic rr);
        @(posedge clk);
        #1;
        drive(rv, data, rr);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(4'b0000, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'b1111, 16'hFFFF, 1'b1);

        vecs[0]  = '{4'b0001, 16'h0005, 1'b1, 4'b0001, 1'b0, 4'd0,     2'd0, 1'b0};
        vecs[1]  = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 4'd6,     2'd0, 1'b0};
        vecs[2]  = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'd6,     2'd0, 1'b0};
        vecs[3]  = '{4'b0010, 16'h00F0, 1'b1, 4'b0010, 1'b0, 4'd6,     2'd0, 1'b0};
        vecs[4]  = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, WRAP_RES, 2'd1, 1'b1};
        vecs[5]  = '{4'b1111, 16'h4321, 1'b1, 4'b0100, 1'b0, WRAP_RES, 2'd1, 1'b1};
        vecs[6]  = '{4'b1111, 16'h4321, 1'b1, 4'b1000, 1'b1, 4'd4,     2'd2, 1'b0};
        vecs[7]  = '{4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'd5,     2'd3, 1'b0};
        vecs[8]  = '{4'b1111, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'd2,     2'd0, 1'b0};
        vecs[9]  = '{4'b1111, 16'h4321, 1'b1, 4'b0100, 1'b1, 4'd3,     2'd1, 1'b0};
        vecs[10] = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 4'd4,     2'd2, 1'b0};
        vecs[11] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 4'd4,     2'd2, 1'b0};
        vecs[12] = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'd4,     2'd2, 1'b0};

        // Reset state, with every requester asking.
        @(posedge clk);
        @(negedge clk);
        check_outs("reset", 4'b0000, 1'b0, 4'd0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'b0000, 16'h0000, 1'b0);

        // Table: single op, hold, wrap, round-robin, backpressure hold, drain.
        for (int v = 0; v < 13; v++) begin
            cycle(vecs[v].rv, vecs[v].data, vecs[v].rr);
            check_outs($sformatf("vec%0d", v), vecs[v].rdy, vecs[v].vld,
                       vecs[v].rdata, vecs[v].id, vecs[v].ovf);
        end

        // Backpressure: result 9 held while res_ready=0, then same-cycle grant on release.
        cycle(4'b0001, 16'h0708, 1'b0);
        check("bp grant0", 32'(req_ready), 32'(4'b0001));
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0100, 16'h0708, 1'b0);
            check_outs($sformatf("bp hold%0d", i), 4'b0000, 1'b1, 4'd9, 2'd0, 1'b0);
        end
        cycle(4'b0100, 16'h0708, 1'b1);
        check_outs("bp release", 4'b0100, 1'b1, 4'd9, 2'd0, 1'b0);
        cycle(4'b0000, 16'h0000, 1'b0);
        check_outs("bp next", 4'b0000, 1'b1, 4'd8, 2'd2, 1'b0);

        // Asynchronous reset while FULL, then first grant goes to lowest valid index.
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("async rst", 4'b0000, 1'b0, 4'd0, 2'd0, 1'b0);
        drive(4'b1010, 16'h00A0, 1'b1);
        @(negedge clk);
        check("rst hold ready", 32'(req_ready), 32'(4'b0000));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst grant", 32'(req_ready), 32'(4'b0010));
        cycle(4'b0000, 16'h0000, 1'b1);
        check_outs("post rst res", 4'b0000, 1'b1, 4'd11, 2'd1, 1'b0);

        // Fairness from a fresh reset: grants 0,1,2,3,0 with results streaming.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(4'b1111, 16'h4321, 1'b1);
            check($sformatf("fair grant%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            check($sformatf("fair valid%0d", k), 32'(res_valid), 32'(k > 0));
            if (k > 0) begin
                check($sformatf("fair id%0d", k), 32'(res_id), 32'((k - 1) % 4));
                check($sformatf("fair data%0d", k), 32'(res_data), 32'(((k - 1) % 4) + 2));
            end
        end
        cycle(4'b0000, 16'h0000, 1'b1);

        // Sweep operands 0..14 through requester 2.
        for (int op = 0; op < 15; op++) begin
            cycle(4'b0100, 16'(op << 8), 1'b1);
            check($sformatf("sweep grant%0d", op), 32'(req_ready), 32'(4'b0100));
            exp_q.push_back(W'(op + 1));
            cycle(4'b0000, 16'h0000, 1'b1);
            if (exp_q.size() == 0) begin
                check("sweep queue", 32'(0), 32'(1));
            end else begin
                check_outs($sformatf("sweep op%0d", op), 4'b0000, 1'b1, exp_q.pop_front(), 2'd2, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", num_checks);
        $fatal(1, "timeout");
    end

endmodule
